// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector.
//
// One bit is accepted on X at every rising clk edge where en is high. Q flags
// that the most recent PAT_LEN accepted bits equal PATTERN (MSB = oldest bit).
// Q is either combinational from the history and X (MEALY=1) or registered
// one clock later (MEALY=0). With OVERLAP=0 the history is discarded after a
// match, so the next match needs PAT_LEN fresh bits. match_count counts matches
// since reset and saturates at all-ones.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset, clears all state
//   en           in   bit-valid qualifier for X
//   X            in   serial data bit
//   Q            out  match indication
//   match_count  out  saturating match counter (CNT_W bits)
module seq_detect_param #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 MEALY   = 1'b1,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             X,
  output logic             Q,
  output logic [CNT_W-1:0] match_count
);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("seq_detect_param: PAT_LEN must be within 2..16");
  end

  // fill only needs to reach PAT_LEN-1, which fits in clog2(PAT_LEN) bits.
  localparam int unsigned       FillW   = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FillW-1:0]  FillMax = FillW'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic               q_q;

  logic [PAT_LEN-1:0] window;
  logic               full;
  logic               match;

  always_comb begin
    window = {hist_q, X};
    // Requiring a full history stops post-reset zeros from matching,
    // including for an all-zero PATTERN.
    full   = (fill_q == FillMax);
    match  = en && full && (window == PATTERN);

    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;

    if (en) begin
      hist_d = window[PAT_LEN-2:0];
      if (!full) begin
        fill_d = fill_q + FillW'(1);
      end
      // Non-overlapping: forget the history; stale hist bits are harmless
      // because fill gates the compare until PAT_LEN-1 new bits arrive.
      if (match && !OVERLAP) begin
        fill_d = '0;
      end
    end

    if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      q_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      // Moore register follows match on every edge, en or not.
      q_q    <= match;
    end
  end

  assign Q           = MEALY ? match : q_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param. Five instances share clk/reset/en/X:
//   a: MEALY=1 OVERLAP=1 PATTERN=1011
//   b: MEALY=1 OVERLAP=0 PATTERN=1011
//   c: MEALY=0 OVERLAP=1 PATTERN=1011
//   d: MEALY=1 OVERLAP=1 PATTERN=0000
//   e: MEALY=1 OVERLAP=1 PATTERN=11, CNT_W=2
// Each driven cycle pushes a record (mask of instances to check, expected Q
// vector {e,d,c,b,a}); the monitor pops one record per falling edge.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic X;

  logic       qa, qb, qc, qd, qe;
  logic [7:0] ca, cb, cc, cd;
  logic [1:0] ce;
  wire  [4:0] qv = {qe, qd, qc, qb, qa};

  typedef struct packed {
    logic [4:0] m;
    logic [4:0] q;
  } rec_t;

  rec_t sb[$];
  rec_t mon_r;
  int   checks = 0;
  int   errors = 0;

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .MEALY(1'b1), .OVERLAP(1'b1), .CNT_W(8))
    u_a (.clk(clk), .reset(reset), .en(en), .X(X), .Q(qa), .match_count(ca));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .MEALY(1'b1), .OVERLAP(1'b0), .CNT_W(8))
    u_b (.clk(clk), .reset(reset), .en(en), .X(X), .Q(qb), .match_count(cb));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .MEALY(1'b0), .OVERLAP(1'b1), .CNT_W(8))
    u_c (.clk(clk), .reset(reset), .en(en), .X(X), .Q(qc), .match_count(cc));
  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b0000), .MEALY(1'b1), .OVERLAP(1'b1), .CNT_W(8))
    u_d (.clk(clk), .reset(reset), .en(en), .X(X), .Q(qd), .match_count(cd));
  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .MEALY(1'b1), .OVERLAP(1'b1), .CNT_W(2))
    u_e (.clk(clk), .reset(reset), .en(en), .X(X), .Q(qe), .match_count(ce));

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue its expected Q values.
  task automatic step(input logic e, input logic x, input logic [4:0] m, input logic [4:0] q);
    @(posedge clk);
    #1;
    en = e;
    X  = x;
    sb.push_back('{m: m, q: q});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    en    = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  // Monitor: every record covers one cycle; compare the masked Q bits.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_r = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
        if (mon_r.m[i]) begin
          checks++;
          if (qv[i] !== mon_r.q[i]) begin
            errors++;
            $display("FAIL q_dut%0d: got %b expected %b at %0t", i, qv[i], mon_r.q[i], $time);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    X     = 1'b0;
    #7;
    chk("rst_q", int'(qv), 0);
    chk("rst_cnt_abcd", int'({ca, cb, cc, cd}), 0);
    chk("rst_cnt_e", int'(ce), 0);
    @(posedge clk);
    #2;
    reset = 1'b1;

    // Stream 1,0,1,1,0,1,1 then two idle cycles.
    step(1'b1, 1'b1, 5'b11111, 5'b00000);
    step(1'b1, 1'b0, 5'b11111, 5'b00000);
    step(1'b1, 1'b1, 5'b11111, 5'b00000);
    step(1'b1, 1'b1, 5'b11111, 5'b10011);
    step(1'b1, 1'b0, 5'b11111, 5'b00100);
    step(1'b1, 1'b1, 5'b11111, 5'b00000);
    step(1'b1, 1'b1, 5'b11111, 5'b10001);
    step(1'b0, 1'b0, 5'b11111, 5'b00100);
    step(1'b0, 1'b0, 5'b11111, 5'b00000);
    chk("cnt_a_ovl", int'(ca), 2);
    chk("cnt_b_novl", int'(cb), 1);
    chk("cnt_c_moore", int'(cc), 2);
    chk("cnt_d_none", int'(cd), 0);
    chk("cnt_e_11", int'(ce), 2);

    // All-zero pattern: six zeros, match from the fourth on.
    do_reset();
    step(1'b1, 1'b0, 5'b01000, 5'b00000);
    step(1'b1, 1'b0, 5'b01000, 5'b00000);
    step(1'b1, 1'b0, 5'b01000, 5'b00000);
    step(1'b1, 1'b0, 5'b01000, 5'b01000);
    step(1'b1, 1'b0, 5'b01000, 5'b01000);
    step(1'b1, 1'b0, 5'b01000, 5'b01000);
    step(1'b0, 1'b0, 5'b01000, 5'b00000);
    chk("cnt_d_zeros", int'(cd), 3);

    // en gaps with random X while en is low.
    do_reset();
    step(1'b1, 1'b1, 5'b00101, 5'b00000);
    step(1'b0, 1'($urandom_range(1)), 5'b00101, 5'b00000);
    step(1'b1, 1'b0, 5'b00101, 5'b00000);
    step(1'b0, 1'($urandom_range(1)), 5'b00101, 5'b00000);
    step(1'b0, 1'($urandom_range(1)), 5'b00101, 5'b00000);
    step(1'b1, 1'b1, 5'b00101, 5'b00000);
    step(1'b0, 1'($urandom_range(1)), 5'b00101, 5'b00000);
    step(1'b1, 1'b1, 5'b00101, 5'b00001);
    step(1'b0, 1'b0, 5'b00101, 5'b00100);
    step(1'b0, 1'b0, 5'b00101, 5'b00000);
    chk("cnt_a_gaps", int'(ca), 1);
    chk("cnt_c_gaps", int'(cc), 1);

    // Saturation on the 2-bit counter, then asynchronous reset mid-cycle.
    do_reset();
    step(1'b1, 1'b1, 5'b10000, 5'b00000);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 5'b10000, 5'b10000);
    step(1'b1, 1'b1, 5'b00000, 5'b00000);
    #2;
    chk("cnt_e_sat", int'(ce), 3);
    reset = 1'b0;
    #1;
    chk("async_q_e", int'(qe), 0);
    chk("async_cnt_e", int'(ce), 0);
    chk("async_q_all", int'(qv), 0);
    @(posedge clk);
    #1;
    chk("hold_rst_q", int'(qv), 0);
    chk("hold_rst_cnt_e", int'(ce), 0);
    #1;
    en    = 1'b0;
    reset = 1'b1;

    repeat (2) @(posedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
